// File: rtl/clock_pkg.sv
// Shared clock-display definitions: mode encodings, blink FSM states, field indices.
// Pure declarations; no logic, no latency, no flow control.
package clock_pkg;

    localparam logic [1:0] MODE_CLOCK = 2'd0;
    localparam logic [1:0] MODE_SET   = 2'd1;
    localparam logic [1:0] MODE_ALARM = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLINK = 2'd1,
        HOLD  = 2'd2
    } blink_state_t;

    localparam int FIELD_SEC  = 0;
    localparam int FIELD_MIN  = 1;
    localparam int FIELD_HOUR = 2;

endpackage

// File: rtl/blink_ctrl_if.sv
// Mode/key FSM to blink controller bundle; alarm_active exists only with BLINK_ALARM_EN.
// Level signals plus a one-cycle edit strobe; there is no backpressure.
interface blink_ctrl_if #(
    parameter int NUM_FIELDS = 3,
    parameter int POS_W      = 2
);
    logic [1:0]            setting_mode;
    logic [POS_W-1:0]      setting_position;
    logic                  edit_pulse;
    logic [NUM_FIELDS-1:0] field_mask;
    logic                  blink_phase;
    logic                  blink_tick;
`ifdef BLINK_ALARM_EN
    logic                  alarm_active;

    modport master (output setting_mode, setting_position, edit_pulse, alarm_active,
                    input  field_mask, blink_phase, blink_tick);
    modport slave  (input  setting_mode, setting_position, edit_pulse, alarm_active,
                    output field_mask, blink_phase, blink_tick);
`else
    modport master (output setting_mode, setting_position, edit_pulse,
                    input  field_mask, blink_phase, blink_tick);
    modport slave  (input  setting_mode, setting_position, edit_pulse,
                    output field_mask, blink_phase, blink_tick);
`endif
endinterface

// File: rtl/blink_ctrl_tick_gen.sv
// Free-running TICK_DIV prescaler; blink_tick is high for the cycle after the count wraps.
// First tick arrives TICK_DIV cycles after reset release; never stalls.
module blink_tick_gen #(
    parameter int TICK_DIV = 5000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int              CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/blink_ctrl.sv
// Per-field blink mask for the setting UI (optional whole-display alarm flash: BLINK_ALARM_EN).
// Outputs registered, mask one cycle behind state/phase; no backpressure.
module blink_ctrl
    import clock_pkg::*;
#(
    parameter int         NUM_FIELDS = 3,
    parameter int         POS_W      = 2,
    parameter int         TICK_DIV   = 5000,
    parameter int         HALF_TICKS = 50,
    parameter int         HOLD_TICKS = 100,
    parameter logic [1:0] SET_MODE   = MODE_SET
) (
    input  logic         clk,
    input  logic         rst_n,
    blink_ctrl_if.slave  bus
);
    localparam int               HALF_W    = $clog2(HALF_TICKS + 1);
    localparam int               HOLD_W    = $clog2(HOLD_TICKS + 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);

    blink_state_t          state, state_n;
    logic [HALF_W-1:0]     half_cnt, half_n;
    logic [HOLD_W-1:0]     hold_cnt, hold_n;
    logic                  phase, phase_n;
    logic                  advance;
    logic [POS_W-1:0]      pos_q;
    logic [NUM_FIELDS-1:0] mask_q, mask_n;
    logic                  tick;

    blink_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            half_cnt <= '0;
            hold_cnt <= '0;
            phase    <= 1'b0;
            pos_q    <= '0;
            mask_q   <= '0;
        end else begin
            state    <= state_n;
            half_cnt <= half_n;
            hold_cnt <= hold_n;
            phase    <= phase_n;
            pos_q    <= bus.setting_position;
            mask_q   <= mask_n;
        end
    end

    always_comb begin
        state_n = state;
        half_n  = half_cnt;
        hold_n  = hold_cnt;
        phase_n = phase;
        advance = 1'b0;

        if (bus.setting_mode != SET_MODE) begin
            state_n = IDLE;
            hold_n  = '0;
`ifdef BLINK_ALARM_EN
            if (bus.alarm_active) begin
                advance = tick;
            end else begin
                half_n  = '0;
                phase_n = 1'b0;
            end
`else
            half_n  = '0;
            phase_n = 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = BLINK;
                    half_n  = '0;
                    phase_n = 1'b0;
                end
                BLINK, HOLD: begin
                    if (bus.edit_pulse) begin
                        // Edit beats a coincident tick: reload rather than decrement.
                        state_n = HOLD;
                        hold_n  = HOLD_LOAD;
                        half_n  = '0;
                        phase_n = 1'b0;
                    end else if (state == HOLD) begin
                        if (tick) begin
                            if (hold_cnt == HOLD_W'(1)) begin
                                state_n = BLINK;
                                hold_n  = '0;
                            end else begin
                                hold_n = hold_cnt - 1'b1;
                            end
                        end
                    end else if (bus.setting_position != pos_q) begin
                        half_n  = '0;
                        phase_n = 1'b0;
                    end else begin
                        advance = tick;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (advance) begin
            if (half_cnt == HALF_LAST) begin
                half_n  = '0;
                phase_n = ~phase;
            end else begin
                half_n = half_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        mask_n = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            mask_n[i] = (state == BLINK) && phase && (bus.setting_position == POS_W'(i));
        end
`ifdef BLINK_ALARM_EN
        if (state == IDLE && bus.alarm_active) begin
            mask_n = {NUM_FIELDS{phase}};
        end
`endif
    end

    assign bus.field_mask  = mask_q;
    assign bus.blink_phase = phase;
    assign bus.blink_tick  = tick;
endmodule

// File: tb/tb_blink_ctrl.sv
// Directed, table-driven bench for blink_ctrl with TICK_DIV=4, HALF_TICKS=2, HOLD_TICKS=3.
module tb_blink_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    blink_ctrl_if #(.NUM_FIELDS(3), .POS_W(2)) bus ();

    blink_ctrl #(
        .NUM_FIELDS (3),
        .POS_W      (2),
        .TICK_DIV   (4),
        .HALF_TICKS (2),
        .HOLD_TICKS (3),
        .SET_MODE   (2'd1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0] mode;
        logic [1:0] pos;
        logic       edit;
        int         len;
        logic [2:0] mask;
        logic       phase;
    } vec_t;

    vec_t vecs [26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] mode, input logic [1:0] pos, input logic edit);
        bus.setting_mode     = mode;
        bus.setting_position = pos;
        bus.edit_pulse       = edit;
    endtask

    initial begin
        int  k;
        bit  found;

        // Each record holds its inputs for len cycles; mask/phase expected constant over the run.
        vecs[0]  = '{2'd0, 2'd0, 1'b0, 40, 3'b000, 1'b0};
        vecs[1]  = '{2'd1, 2'd1, 1'b0,  8, 3'b000, 1'b0};
        vecs[2]  = '{2'd1, 2'd1, 1'b0,  1, 3'b000, 1'b1};
        vecs[3]  = '{2'd1, 2'd1, 1'b0,  7, 3'b010, 1'b1};
        vecs[4]  = '{2'd1, 2'd1, 1'b0,  1, 3'b010, 1'b0};
        vecs[5]  = '{2'd1, 2'd1, 1'b0,  7, 3'b000, 1'b0};
        vecs[6]  = '{2'd1, 2'd1, 1'b0,  1, 3'b000, 1'b1};
        vecs[7]  = '{2'd1, 2'd1, 1'b0,  4, 3'b010, 1'b1};
        vecs[8]  = '{2'd1, 2'd2, 1'b0,  1, 3'b100, 1'b0};
        vecs[9]  = '{2'd1, 2'd2, 1'b0,  6, 3'b000, 1'b0};
        vecs[10] = '{2'd1, 2'd2, 1'b0,  1, 3'b000, 1'b1};
        vecs[11] = '{2'd1, 2'd2, 1'b0,  3, 3'b100, 1'b1};
        vecs[12] = '{2'd1, 2'd2, 1'b1,  1, 3'b100, 1'b0};
        vecs[13] = '{2'd1, 2'd2, 1'b0,  7, 3'b000, 1'b0};
        vecs[14] = '{2'd1, 2'd2, 1'b1,  1, 3'b000, 1'b0};
        vecs[15] = '{2'd1, 2'd2, 1'b0, 19, 3'b000, 1'b0};
        vecs[16] = '{2'd1, 2'd2, 1'b0,  1, 3'b000, 1'b1};
        vecs[17] = '{2'd1, 2'd2, 1'b0,  3, 3'b100, 1'b1};
        vecs[18] = '{2'd1, 2'd3, 1'b0,  8, 3'b000, 1'b0};
        vecs[19] = '{2'd1, 2'd3, 1'b0,  4, 3'b000, 1'b1};
        vecs[20] = '{2'd1, 2'd1, 1'b0,  1, 3'b010, 1'b0};
        vecs[21] = '{2'd1, 2'd1, 1'b0,  7, 3'b000, 1'b0};
        vecs[22] = '{2'd1, 2'd1, 1'b0,  1, 3'b000, 1'b1};
        vecs[23] = '{2'd1, 2'd1, 1'b0,  3, 3'b010, 1'b1};
        vecs[24] = '{2'd0, 2'd1, 1'b0,  1, 3'b010, 1'b0};
        vecs[25] = '{2'd0, 2'd1, 1'b0,  4, 3'b000, 1'b0};

        drive(2'd0, 2'd0, 1'b0);
`ifdef BLINK_ALARM_EN
        bus.alarm_active = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_mask",  32'(bus.field_mask), 32'd0);
        check("reset_phase", 32'(bus.blink_phase), 32'd0);
        check("reset_tick",  32'(bus.blink_tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        k = 0;
        for (int v = 0; v < 26; v++) begin
            for (int c = 0; c < vecs[v].len; c++) begin
                drive(vecs[v].mode, vecs[v].pos, vecs[v].edit);
                @(posedge clk);
                #1;
                k++;
                check($sformatf("vec%0d_c%0d_mask", v, k),  32'(bus.field_mask),  32'(vecs[v].mask));
                check($sformatf("vec%0d_c%0d_phase", v, k), 32'(bus.blink_phase), 32'(vecs[v].phase));
                check($sformatf("vec%0d_c%0d_tick", v, k),  32'(bus.blink_tick),  32'((k % 4) == 0));
            end
        end

        // Enter HOLD, then pull reset while a tick is on the output.
        drive(2'd1, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        drive(2'd1, 2'd0, 1'b1);
        @(posedge clk);
        #1;
        drive(2'd1, 2'd0, 1'b0);
        found = bus.blink_tick;
        for (int w = 0; w < 8 && !found; w++) begin
            @(posedge clk);
            #1;
            found = bus.blink_tick;
        end
        check("hold_tick_seen", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_mask",  32'(bus.field_mask), 32'd0);
        check("async_rst_phase", 32'(bus.blink_phase), 32'd0);
        check("async_rst_tick",  32'(bus.blink_tick), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst_tick_j%0d", j), 32'(bus.blink_tick), 32'(j == 4 || j == 8));
            check($sformatf("post_rst_phase_j%0d", j), 32'(bus.blink_phase), 32'(j >= 9));
            check($sformatf("post_rst_mask_j%0d", j), 32'(bus.field_mask), (j == 10) ? 32'd1 : 32'd0);
        end

`ifdef BLINK_ALARM_EN
        drive(2'd0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.alarm_active = 1'b1;
        for (int j = 1; j <= 26; j++) begin
            if (j == 26) bus.alarm_active = 1'b0;
            @(posedge clk);
            #1;
            if (j == 26) begin
                check("alarm_fall_mask",  32'(bus.field_mask), 32'd0);
                check("alarm_fall_phase", 32'(bus.blink_phase), 32'd0);
            end else begin
                check($sformatf("alarm_mask_j%0d", j), 32'(bus.field_mask),
                      (j >= 10 && (((j - 2) / 8) % 2) == 1) ? 32'h7 : 32'h0);
                check($sformatf("alarm_phase_j%0d", j), 32'(bus.blink_phase),
                      32'(j >= 9 && (((j - 1) / 8) % 2) == 1));
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
